svc_rv_soc_run_ctrl: RTL and testbench

Run sequencer for an SRAM-based RISC-V SoC demo. It owns the SoC's active-low reset and holds the core in reset until a start request arrives. It then releases the core and counts cycles until the core reports ebreak or a timeout expires. It presents the cycle count and status through a valid/ready result port, then returns the core to reset, so board-level demos and benches can measure whole-program runtime and re-run on demand.

---
 rtl/svc_rv_soc_run_ctrl_pkg.sv | 14 +
 rtl/svc_rv_soc_run_ctrl.sv | 82 ++++++++
 tb/tb_svc_rv_soc_run_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/svc_rv_soc_run_ctrl_pkg.sv
// Shared types for the SoC run sequencer.
// State encoding and run counter width.
package svc_rv_soc_run_ctrl_pkg;

  localparam int RUN_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } run_state_e;

endpackage

// File: rtl/svc_rv_soc_run_ctrl.sv
// Run sequencer: holds the SoC in reset, releases it, times the
// program until ebreak or timeout and hands out the cycle count.
module svc_rv_soc_run_ctrl
  import svc_rv_soc_run_ctrl_pkg::*;
#(
  parameter int CYCLE_W      = 32,
  parameter int RST_CYCLES   = 4,
  parameter int TIMEOUT      = 1048576,
  parameter bit AUTO_RESTART = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 soc_ebreak,
  output logic                 soc_rst_n,
  output logic                 busy,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [CYCLE_W-1:0]   result_cycles,
  output logic                 result_timeout,
  output logic [RUN_CNT_W-1:0] run_count
);

  localparam int HOLD_W = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [CYCLE_W-1:0] TO = CYCLE_W'(TIMEOUT);

  run_state_e         state_q;
  run_state_e         state_d;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [CYCLE_W-1:0] cyc_cnt;
  logic [CYCLE_W-1:0] cyc_inc;
  logic               hit_to;
  logic               run_end;

  // Saturating increment keeps an unbounded run from wrapping.
  assign cyc_inc = (&cyc_cnt) ? cyc_cnt : cyc_cnt + 1'b1;
  assign hit_to  = (TIMEOUT != 0) && (cyc_inc == TO);
  assign run_end = (state_q == ST_RUN) && (soc_ebreak || hit_to);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_HOLD;
      ST_HOLD: if (hold_cnt == HOLD_LAST) state_d = ST_RUN;
      ST_RUN:  if (soc_ebreak || hit_to) state_d = ST_DONE;
      ST_DONE: begin
        if (result_ready)
          state_d = AUTO_RESTART ? ST_HOLD : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      soc_rst_n      <= 1'b0;
      busy           <= 1'b0;
      result_valid   <= 1'b0;
      result_cycles  <= '0;
      result_timeout <= 1'b0;
      run_count      <= '0;
      hold_cnt       <= '0;
      cyc_cnt        <= '0;
    end else begin
      state_q      <= state_d;
      soc_rst_n    <= (state_d == ST_RUN);
      busy         <= (state_d != ST_IDLE);
      result_valid <= (state_d == ST_DONE);
      hold_cnt     <= (state_q == ST_HOLD) ? hold_cnt + 1'b1 : '0;
      cyc_cnt      <= (state_q == ST_RUN) ? cyc_inc : '0;
      // Ebreak wins a tie with timeout.
      if (run_end) begin
        result_cycles  <= cyc_inc;
        result_timeout <= ~soc_ebreak;
        run_count      <= run_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_svc_rv_soc_run_ctrl.sv
// Bench for the run sequencer: one manual-restart instance with a
// short timeout, one auto-restart instance with a narrow saturating counter.
module tb_svc_rv_soc_run_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_start, a_eb, a_rst_n, a_busy, a_valid, a_ready, a_to;
  logic [31:0] a_cyc;
  logic [15:0] a_rc;
  logic        b_start, b_eb, b_rst_n, b_busy, b_valid, b_ready, b_to;
  logic [3:0]  b_cyc;
  logic [15:0] b_rc;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_a_runs;
  logic [15:0] exp_b_runs;

  svc_rv_soc_run_ctrl #(
    .CYCLE_W(32), .RST_CYCLES(4), .TIMEOUT(16), .AUTO_RESTART(1'b0)
  ) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .soc_ebreak(a_eb),
    .soc_rst_n(a_rst_n), .busy(a_busy), .result_valid(a_valid),
    .result_ready(a_ready), .result_cycles(a_cyc),
    .result_timeout(a_to), .run_count(a_rc)
  );

  svc_rv_soc_run_ctrl #(
    .CYCLE_W(4), .RST_CYCLES(2), .TIMEOUT(0), .AUTO_RESTART(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .soc_ebreak(b_eb),
    .soc_rst_n(b_rst_n), .busy(b_busy), .result_valid(b_valid),
    .result_ready(b_ready), .result_cycles(b_cyc),
    .result_timeout(b_to), .run_count(b_rc)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Reference: eb = RUN cycle index of ebreak (0 = never).
  function automatic int exp_cycles(input int eb, input int tmo,
                                    input int w);
    int lim;
    if (tmo != 0) return (eb != 0 && eb <= tmo) ? eb : tmo;
    lim = (1 << w) - 1;
    return (eb > lim) ? lim : eb;
  endfunction

  function automatic int exp_to(input int eb, input int tmo);
    return (tmo != 0 && (eb == 0 || eb > tmo)) ? 1 : 0;
  endfunction

  task automatic run_a(input int eb, input bit eb_in_hold,
                       input int rdy_dly);
    int hold;
    int k;
    logic [31:0] c0;
    logic        t0;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    a_eb = eb_in_hold;
    hold = 0;
    while (!a_rst_n && hold < 20) begin
      hold++;
      @(negedge clk);
    end
    chk("a_hold_len", hold, 4);
    k = 1;
    while (!a_valid && k < 100) begin
      a_eb = (k == eb);
      @(negedge clk);
      k++;
    end
    a_eb = 1'b0;
    exp_a_runs++;
    chk("a_valid", a_valid, 1);
    chk("a_cycles", a_cyc, exp_cycles(eb, 16, 32));
    chk("a_timeout", a_to, exp_to(eb, 16));
    chk("a_run_count", a_rc, exp_a_runs);
    chk("a_rst_n_done", a_rst_n, 0);
    c0 = a_cyc;
    t0 = a_to;
    for (int i = 0; i < rdy_dly; i++) begin
      a_start = i[0];
      a_eb = 1'b1;
      @(negedge clk);
      chk("a_hold_valid", a_valid, 1);
      chk("a_hold_cycles", a_cyc, c0);
      chk("a_hold_to", a_to, t0);
      chk("a_hold_rc", a_rc, exp_a_runs);
    end
    a_start = 1'b0;
    a_eb = 1'b0;
    a_ready = 1'b1;
    @(negedge clk);
    a_ready = 1'b0;
    chk("a_valid_clr", a_valid, 0);
    chk("a_idle", a_busy, 0);
    @(negedge clk);
    chk("a_no_queue", a_busy, 0);
  endtask

  task automatic run_b(input int eb, input bit preload);
    int w;
    int k;
    w = 0;
    while (!b_rst_n && w < 20) begin
      w++;
      @(negedge clk);
    end
    chk("b_release", b_rst_n, 1);
    if (preload) begin
      force dut_b.run_count = 16'hFFFF;
      #1;
      release dut_b.run_count;
      exp_b_runs = 16'hFFFF;
    end
    k = 1;
    while (!b_valid && k < 100) begin
      b_eb = (k == eb);
      @(negedge clk);
      k++;
    end
    b_eb = 1'b0;
    exp_b_runs++;
    chk("b_valid", b_valid, 1);
    chk("b_cycles", b_cyc, exp_cycles(eb, 0, 4));
    chk("b_timeout", b_to, 0);
    chk("b_run_count", b_rc, exp_b_runs);
  endtask

  initial begin
    rst = 1'b1;
    a_start = 1'b0; a_eb = 1'b0; a_ready = 1'b0;
    b_start = 1'b0; b_eb = 1'b0; b_ready = 1'b1;
    exp_a_runs = '0;
    exp_b_runs = '0;
    repeat (3) @(negedge clk);
    chk("rst_a_rst_n", a_rst_n, 0);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_valid", a_valid, 0);
    chk("rst_a_cycles", a_cyc, 0);
    chk("rst_a_to", a_to, 0);
    chk("rst_a_rc", a_rc, 0);
    chk("rst_b_busy", b_busy, 0);
    chk("rst_b_valid", b_valid, 0);
    rst = 1'b0;
    @(negedge clk);

    run_a(11, 1'b0, 0);
    run_a(0, 1'b0, 2);
    run_a(16, 1'b1, 5);
    run_a(17, 1'b0, 1);
    for (int i = 0; i < 8; i++)
      run_a($urandom_range(0, 20), 1'($urandom_range(0, 1)),
            $urandom_range(0, 5));

    // Reset in the middle of a run.
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_in_run", a_rst_n, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_a_runs = '0;
    chk("mid_rst_n", a_rst_n, 0);
    chk("mid_busy", a_busy, 0);
    chk("mid_valid", a_valid, 0);
    chk("mid_rc", a_rc, 0);
    chk("mid_cycles", a_cyc, 0);
    run_a(5, 1'b0, 1);

    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    run_b(3, 1'b0);
    run_b(3, 1'b0);
    run_b(3, 1'b0);
    run_b(20, 1'b0);
    run_b($urandom_range(1, 14), 1'b0);
    run_b(3, 1'b1);
    run_b(3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
